wb_commit_ctrl: RTL and testbench
=================================

Name: wb_commit_ctrl

Overview:
- Commit sequencer for the dual-issue WB stage.
- Lane 1 (ms1) always holds the older instruction and lane 2 (ms2) the younger. The two lanes arrive from MEM independently.
- The block gates when each lane may enter WB and when each lane's WB bus register captures.
- It retires the pair in program order, turns an exception or ERET into a single-instruction commit, raises the pipeline flush, and counts retired instructions.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  core clock
- resetn  in  1  asynchronous active-low reset
- ms1_to_ws_valid  in  1  lane-1 instruction offered by MEM
- ms1_paired  in  1  lane-1 instruction was dual-issued with a lane-2 partner
- ms1_ex  in  1  lane-1 carries an exception
- ms1_eret  in  1  lane-1 is ERET
- ms2_to_ws_valid  in  1  lane-2 instruction offered by MEM
- ms2_ex  in  1  lane-2 carries an exception
- ws_allowin_1  out  1  WB accepts lane 1 this cycle
- ws_allowin_2  out  1  WB accepts lane 2 this cycle
- ws_cap_1  out  1  load enable for the lane-1 WB bus register
- ws_cap_2  out  1  load enable for the lane-2 WB bus register
- commit_1  out  1  lane-1 retires this cycle; RF/debug write enable qualifier
- commit_2  out  1  lane-2 retires this cycle
- ws_ex_flush  out  1  one-cycle flush of IF..MEM and CP0 exception entry
- ws_ex_lane  out  1  lane that raised the flush (0 = lane 1, 1 = lane 2)
- commit_cnt  out  CNT_W  retired-instruction counter

Behaviour:
- Clock and reset: one clock, clk. resetn is asynchronous and active-low; asserting it forces state IDLE and commit_cnt to 0 immediately.
- Registered outputs: commit_1, commit_2, ws_ex_flush and ws_ex_lane are registered and reset to 0.
- Decoded outputs: ws_allowin_1 and ws_allowin_2 are decoded from the state. Out of reset they are both 1 (IDLE).
- Captures: ws_cap_1 = ms1_to_ws_valid & ws_allowin_1; ws_cap_2 = ms2_to_ws_valid & ws_allowin_2. Both are 0 while resetn is low.
- State encoding: IDLE, WAIT_L1, WAIT_L2, COMMIT_DUAL, COMMIT_SINGLE (one-hot, 5 bits).
- Define k1 = ms1_ex | ms1_eret, the "kill" condition of lane 1.
- Allowin by state:
  - IDLE: allowin_1 = 1, allowin_2 = 1.
  - WAIT_L1: allowin_1 = 1, allowin_2 = 0.
  - WAIT_L2: allowin_1 = 0, allowin_2 = 1.
  - Both COMMIT states: both allowins = 0. This costs one bubble per commit, by design.
- Transitions from IDLE:
  - cap_1 & cap_2 -> COMMIT_SINGLE if k1, else COMMIT_DUAL.
  - cap_1 only -> COMMIT_SINGLE if ~ms1_paired or k1, else WAIT_L2.
  - cap_2 only -> WAIT_L1.
  - Neither -> stay in IDLE.
- Transitions from WAIT_L1: cap_1 -> COMMIT_SINGLE if k1, else COMMIT_DUAL; otherwise hold.
- Transitions from WAIT_L2: cap_2 -> COMMIT_DUAL; otherwise hold.
- COMMIT_DUAL (one cycle, then IDLE):
  - commit_1 = 1 and commit_2 = 1.
  - If the latched lane-2 ms2_ex is set: commit_2 = 0, ws_ex_flush = 1, ws_ex_lane = 1.
- COMMIT_SINGLE (one cycle, then IDLE):
  - commit_1 = 1 and commit_2 = 0.
  - Any lane-2 instruction held in WB is dropped.
  - If the latched lane-1 k1 is set: ws_ex_flush = 1, ws_ex_lane = 0.
- Latched flags: ms1_ex, ms1_eret and ms2_ex are latched on their lane's capture. Commit decisions use the latched copies.
- Flush scope: the flush clears all upstream stages, so a lane-2 partner of an excepting lane-1 never arrives later. No drop-pending state exists.
- commit_cnt: on each COMMIT cycle it increments by the number of commits whose instruction is not excepting (ERET counts as retired). The increment is 0, 1 or 2, and the counter wraps modulo 2^CNT_W.
- Illegal encodings: any illegal state decodes to IDLE on the next clock.
- Reset mid-operation: a half-captured pair is discarded and no commit pulse is emitted.

Decomposition:
- Shared package/header (mycpu.h): state one-hot localparams, COMMIT_W = 5, and the CNT_W default.
- No sub-module. A single always-block FSM plus the counter is natural.
- The flag latches live inside the block.

Test Plan:
- Pair together: resetn low for 3 cycles, then ms1 valid (paired=1) and ms2 valid in the same cycle. Expect cap_1 = cap_2 = 1; next cycle commit_1 = commit_2 = 1; commit_cnt 0 -> 2; allowins = 0 for exactly 1 cycle.
- Lane 2 first: ms2 valid at cycle t, ms1 valid at t+3. Expect the state held in WAIT_L1 with allowin_2 = 0 during t+1..t+3; dual commit at t+4; commit_cnt += 2.
- Lane-1 exception, lane 2 already held: ms2 captured, then ms1 arrives with ms1_ex = 1. Expect COMMIT_SINGLE with commit_1 = 1, commit_2 = 0, ws_ex_flush = 1, ws_ex_lane = 0; commit_cnt unchanged.
- Lane-2 exception: both captured, ms2_ex = 1. Expect commit_1 = 1, commit_2 = 0, ws_ex_flush = 1, ws_ex_lane = 1; commit_cnt += 1.
- Unpaired lane 1 and ERET: ms1 alone with paired = 0, then an ERET paired = 1. Expect a single commit for each with no WAIT state; flush only on the ERET; commit_cnt += 2 in total.
- Counter wrap: preload commit_cnt to 2^CNT_W-1 via a run with CNT_W = 4, then a dual commit. Expect commit_cnt = 1.
- Reset mid-operation: deassert resetn while in WAIT_L2. Expect immediate IDLE, both allowins = 1, and commit_cnt = 0.

Source files
------------

// File: rtl/wb_commit_ctrl_pkg.sv
// Shared constants for the dual-issue WB commit sequencer.
// Holds the one-hot state encodings and the default retired-counter width.
package wb_commit_ctrl_pkg;

  localparam int COMMIT_W  = 5;
  localparam int CNT_W_DEF = 32;

  localparam logic [COMMIT_W-1:0] ST_IDLE          = 5'b00001;
  localparam logic [COMMIT_W-1:0] ST_WAIT_L1       = 5'b00010;
  localparam logic [COMMIT_W-1:0] ST_WAIT_L2       = 5'b00100;
  localparam logic [COMMIT_W-1:0] ST_COMMIT_DUAL   = 5'b01000;
  localparam logic [COMMIT_W-1:0] ST_COMMIT_SINGLE = 5'b10000;

endpackage

// File: rtl/wb_commit_ctrl.sv
// WB-stage commit sequencer: gates lane entry into WB, retires the pair in
// program order, collapses exceptions/ERET to a single commit and counts retires.
module wb_commit_ctrl
  import wb_commit_ctrl_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             ms1_to_ws_valid,
  input  logic             ms1_paired,
  input  logic             ms1_ex,
  input  logic             ms1_eret,
  input  logic             ms2_to_ws_valid,
  input  logic             ms2_ex,
  output logic             ws_allowin_1,
  output logic             ws_allowin_2,
  output logic             ws_cap_1,
  output logic             ws_cap_2,
  output logic             commit_1,
  output logic             commit_2,
  output logic             ws_ex_flush,
  output logic             ws_ex_lane,
  output logic [CNT_W-1:0] commit_cnt
);

  logic [COMMIT_W-1:0] state;
  logic [COMMIT_W-1:0] state_n;
  logic                ex1_l;
  logic                eret1_l;
  logic                ex2_l;
  logic                k1;
  logic                k1_n;
  logic                ex2_n;
  logic                commit_1_n;
  logic                commit_2_n;
  logic                flush_n;
  logic                lane_n;
  logic                in_commit;
  logic [CNT_W-1:0]    inc;

  // Illegal encodings close both gates so nothing is captured before recovery.
  always_comb begin
    ws_allowin_1 = 1'b0;
    ws_allowin_2 = 1'b0;
    case (state)
      ST_IDLE:    begin ws_allowin_1 = 1'b1; ws_allowin_2 = 1'b1; end
      ST_WAIT_L1: ws_allowin_1 = 1'b1;
      ST_WAIT_L2: ws_allowin_2 = 1'b1;
      default:    ;
    endcase
  end

  assign ws_cap_1 = ms1_to_ws_valid & ws_allowin_1 & resetn;
  assign ws_cap_2 = ms2_to_ws_valid & ws_allowin_2 & resetn;
  assign k1       = ms1_ex | ms1_eret;

  always_comb begin
    state_n = ST_IDLE;
    case (state)
      ST_IDLE: begin
        if (ws_cap_1 && ws_cap_2)
          state_n = k1 ? ST_COMMIT_SINGLE : ST_COMMIT_DUAL;
        else if (ws_cap_1)
          state_n = (!ms1_paired || k1) ? ST_COMMIT_SINGLE : ST_WAIT_L2;
        else if (ws_cap_2)
          state_n = ST_WAIT_L1;
        else
          state_n = ST_IDLE;
      end
      ST_WAIT_L1: begin
        if (ws_cap_1)
          state_n = k1 ? ST_COMMIT_SINGLE : ST_COMMIT_DUAL;
        else
          state_n = ST_WAIT_L1;
      end
      ST_WAIT_L2: state_n = ws_cap_2 ? ST_COMMIT_DUAL : ST_WAIT_L2;
      default:    state_n = ST_IDLE;
    endcase
  end

  // Commit outputs are registered, so decide them from the flag values that
  // will be latched at the same edge that enters the commit state.
  always_comb begin
    k1_n       = ws_cap_1 ? k1 : (ex1_l | eret1_l);
    ex2_n      = ws_cap_2 ? ms2_ex : ex2_l;
    commit_1_n = (state_n == ST_COMMIT_DUAL) || (state_n == ST_COMMIT_SINGLE);
    commit_2_n = (state_n == ST_COMMIT_DUAL) && !ex2_n;
    lane_n     = (state_n == ST_COMMIT_DUAL) && ex2_n;
    flush_n    = lane_n || ((state_n == ST_COMMIT_SINGLE) && k1_n);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= ST_IDLE;
      commit_1    <= 1'b0;
      commit_2    <= 1'b0;
      ws_ex_flush <= 1'b0;
      ws_ex_lane  <= 1'b0;
    end else begin
      state       <= state_n;
      commit_1    <= commit_1_n;
      commit_2    <= commit_2_n;
      ws_ex_flush <= flush_n;
      ws_ex_lane  <= lane_n;
    end
  end

  always_ff @(posedge clk) begin
    if (ws_cap_1) begin
      ex1_l   <= ms1_ex;
      eret1_l <= ms1_eret;
    end
    if (ws_cap_2)
      ex2_l <= ms2_ex;
  end

  // An excepting lane-1 does not retire; ERET does.
  assign in_commit = (state == ST_COMMIT_DUAL) || (state == ST_COMMIT_SINGLE);
  assign inc       = CNT_W'(commit_1 & ~ex1_l) + CNT_W'(commit_2);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      commit_cnt <= '0;
    else if (in_commit)
      commit_cnt <= commit_cnt + inc;
  end

endmodule

// File: tb/tb_wb_commit_ctrl.sv
// Bench for wb_commit_ctrl (4-bit counter): per-cycle vector table with a
// scoreboard queue for the registered outputs, plus hand-written reset sequences.
module tb_wb_commit_ctrl;

  logic       clk = 1'b0;
  logic       resetn;
  logic       ms1_to_ws_valid, ms1_paired, ms1_ex, ms1_eret;
  logic       ms2_to_ws_valid, ms2_ex;
  logic       ws_allowin_1, ws_allowin_2, ws_cap_1, ws_cap_2;
  logic       commit_1, commit_2, ws_ex_flush, ws_ex_lane;
  logic [3:0] commit_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_commit_ctrl #(.CNT_W(4)) dut (
    .clk(clk), .resetn(resetn),
    .ms1_to_ws_valid(ms1_to_ws_valid), .ms1_paired(ms1_paired),
    .ms1_ex(ms1_ex), .ms1_eret(ms1_eret),
    .ms2_to_ws_valid(ms2_to_ws_valid), .ms2_ex(ms2_ex),
    .ws_allowin_1(ws_allowin_1), .ws_allowin_2(ws_allowin_2),
    .ws_cap_1(ws_cap_1), .ws_cap_2(ws_cap_2),
    .commit_1(commit_1), .commit_2(commit_2),
    .ws_ex_flush(ws_ex_flush), .ws_ex_lane(ws_ex_lane),
    .commit_cnt(commit_cnt)
  );

  // One row per cycle: inputs, gates/captures this cycle, registered outputs after the edge.
  typedef struct packed {
    logic       v1, pr, e1, er, v2, e2;
    logic       a1, a2, k1, k2;
    logic       c1, c2, fl, ln;
    logic [3:0] cnt;
  } vec_t;

  typedef struct {
    int         row;
    logic [3:0] outs;
    logic [3:0] cnt;
  } exp_t;

  localparam int NVEC = 28;
  vec_t tbl [NVEC];
  exp_t sb [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic drive(input logic v1, input logic pr, input logic e1,
                       input logic er, input logic v2, input logic e2);
    ms1_to_ws_valid = v1; ms1_paired = pr; ms1_ex = e1; ms1_eret = er;
    ms2_to_ws_valid = v2; ms2_ex = e2;
  endtask

  initial begin
    // pair together, then held valids blocked by the commit bubble
    tbl[0]  = 18'b110010_1111_1100_0000;
    tbl[1]  = 18'b110010_0000_0000_0010;
    // lane 2 first, lane 1 three cycles later
    tbl[2]  = 18'b000010_1101_0000_0010;
    tbl[3]  = 18'b000010_1000_0000_0010;
    tbl[4]  = 18'b000000_1000_0000_0010;
    tbl[5]  = 18'b110000_1010_1100_0010;
    tbl[6]  = 18'b000000_0000_0000_0100;
    // lane-1 exception with lane 2 already held
    tbl[7]  = 18'b000010_1101_0000_0100;
    tbl[8]  = 18'b111000_1010_1010_0100;
    tbl[9]  = 18'b000000_0000_0000_0100;
    // lane-2 exception
    tbl[10] = 18'b110011_1111_1011_0100;
    tbl[11] = 18'b000000_0000_0000_0101;
    // unpaired lane 1, then paired ERET
    tbl[12] = 18'b100000_1110_1000_0101;
    tbl[13] = 18'b000000_0000_0000_0110;
    tbl[14] = 18'b110100_1110_1010_0110;
    tbl[15] = 18'b000000_0000_0000_0111;
    // lane 1 first; ms1_ex toggling after capture must be ignored
    tbl[16] = 18'b110000_1110_0000_0111;
    tbl[17] = 18'b001000_0100_0000_0111;
    tbl[18] = 18'b001010_0101_1100_0111;
    tbl[19] = 18'b000000_0000_0000_1001;
    // dual commits up to 15, then wrap to 1
    tbl[20] = 18'b110010_1111_1100_1001;
    tbl[21] = 18'b000000_0000_0000_1011;
    tbl[22] = 18'b110010_1111_1100_1011;
    tbl[23] = 18'b000000_0000_0000_1101;
    tbl[24] = 18'b110010_1111_1100_1101;
    tbl[25] = 18'b000000_0000_0000_1111;
    tbl[26] = 18'b110010_1111_1100_1111;
    tbl[27] = 18'b000000_0000_0000_0001;

    resetn = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("reset_allowin", {ws_allowin_1, ws_allowin_2}, 2'b11);
    check("reset_cap", {ws_cap_1, ws_cap_2}, 2'b00);
    check("reset_outs", {commit_1, commit_2, ws_ex_flush, ws_ex_lane}, 4'b0000);
    check("reset_cnt", commit_cnt, 4'd0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    resetn = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < NVEC; i++) begin
      exp_t e;
      drive(tbl[i].v1, tbl[i].pr, tbl[i].e1, tbl[i].er, tbl[i].v2, tbl[i].e2);
      #1;
      check($sformatf("row%0d_gate", i),
            {ws_allowin_1, ws_allowin_2, ws_cap_1, ws_cap_2},
            {tbl[i].a1, tbl[i].a2, tbl[i].k1, tbl[i].k2});
      e.row  = i;
      e.outs = {tbl[i].c1, tbl[i].c2, tbl[i].fl, tbl[i].ln};
      e.cnt  = tbl[i].cnt;
      sb.push_back(e);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
        check("scoreboard_empty", 32'd0, 32'd1);
      end else begin
        e = sb.pop_front();
        check($sformatf("row%0d_commit", e.row),
              {commit_1, commit_2, ws_ex_flush, ws_ex_lane}, e.outs);
        check($sformatf("row%0d_cnt", e.row), commit_cnt, e.cnt);
      end
    end

    // reset while waiting for lane 2: pair must be discarded
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    #1;
    check("midrst_wait_l2", {ws_allowin_1, ws_allowin_2}, 2'b01);
    resetn = 1'b0;
    #1;
    check("midrst_allowin", {ws_allowin_1, ws_allowin_2}, 2'b11);
    check("midrst_cap", {ws_cap_1, ws_cap_2}, 2'b00);
    check("midrst_cnt", commit_cnt, 4'd0);
    check("midrst_outs", {commit_1, commit_2, ws_ex_flush, ws_ex_lane}, 4'b0000);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    #1;
    // lane 2 alone now must wait for a fresh lane 1, not complete the old pair
    @(posedge clk);
    #1;
    check("postrst_no_commit", {commit_1, commit_2}, 2'b00);
    check("postrst_wait_l1", {ws_allowin_1, ws_allowin_2}, 2'b10);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("postrst_dual", {commit_1, commit_2, ws_ex_flush}, 3'b110);
    @(posedge clk);
    #1;
    check("postrst_cnt", commit_cnt, 4'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
